// File: rtl/vend_arbiter.sv
// vend_arbiter: round-robin session arbiter sharing one drink machine
// between two customers. IDLE picks an owner, SERVE forwards the owner's
// coin, WAIT routes the machine's dispense/change answer back to the owner.
// Optional feature macro: VEND_ARB_TIMEOUT_EN. When it is defined, an idle
// owner is force-cancelled after TIMEOUT coin-less SERVE cycles.
module vend_arbiter #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [1:0] coin0,
  input  logic [1:0] coin1,
  output logic       coin_rdy0,
  output logic       coin_rdy1,
  output logic [1:0] grant,
  output logic [1:0] coin_out,
  input  logic       drink_in,
  input  logic [1:0] back_in,
  output logic       drink0,
  output logic       drink1,
  output logic [1:0] back0,
  output logic [1:0] back1
);

  localparam int unsigned CNT_W       = 8;
  localparam logic [1:0]  COIN_NONE   = 2'b00;
  localparam logic [1:0]  COIN_CANCEL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SERVE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t     state, state_d;
  logic       owner, owner_d;
  logic       rr_last, rr_last_d;
  logic       cancel, cancel_d;
  logic [1:0] grant_d;
  logic [1:0] owner_coin;
  logic       pick;
  logic       timeout_hit;

`ifdef VEND_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt, cnt_d;
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
`else
  logic [CNT_W-1:0] timeout_unused;
  assign timeout_hit    = 1'b0;
  assign timeout_unused = CNT_W'(TIMEOUT);
`endif

  // Contention goes to the customer that was not served last.
  assign pick       = (req0 && req1) ? ~rr_last : req1;
  assign owner_coin = owner ? coin1 : coin0;

  // State, owner, pointer, cancel flag and grant registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      owner   <= 1'b0;
      rr_last <= 1'b1;
      cancel  <= 1'b0;
      grant   <= 2'b00;
`ifdef VEND_ARB_TIMEOUT_EN
      cnt     <= '0;
`endif
    end else begin
      state   <= state_d;
      owner   <= owner_d;
      rr_last <= rr_last_d;
      cancel  <= cancel_d;
      grant   <= grant_d;
`ifdef VEND_ARB_TIMEOUT_EN
      cnt     <= cnt_d;
`endif
    end
  end

  // Next-state logic and combinational routing of coins, dispense and change.
  always_comb begin
    state_d   = state;
    owner_d   = owner;
    rr_last_d = rr_last;
    cancel_d  = cancel;
    grant_d   = grant;
`ifdef VEND_ARB_TIMEOUT_EN
    cnt_d     = cnt;
`endif
    coin_out  = COIN_NONE;
    coin_rdy0 = 1'b0;
    coin_rdy1 = 1'b0;
    drink0    = 1'b0;
    drink1    = 1'b0;
    back0     = 2'b00;
    back1     = 2'b00;

    case (state)
      S_IDLE: begin
        if (req0 || req1) begin
          owner_d = pick;
          grant_d = pick ? 2'b10 : 2'b01;
          state_d = S_SERVE;
`ifdef VEND_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      S_SERVE: begin
        if (timeout_hit) begin
          // Forced cancel on behalf of an idle owner; the owner's coin is refused.
          coin_out = COIN_CANCEL;
          cancel_d = 1'b1;
          state_d  = S_WAIT;
`ifdef VEND_ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end else begin
          coin_rdy0 = ~owner;
          coin_rdy1 = owner;
          coin_out  = owner_coin;
          if (owner_coin != COIN_NONE) begin
            cancel_d = (owner_coin == COIN_CANCEL);
            state_d  = S_WAIT;
`ifdef VEND_ARB_TIMEOUT_EN
            cnt_d    = '0;
`endif
          end else begin
`ifdef VEND_ARB_TIMEOUT_EN
            cnt_d = cnt + CNT_W'(1);
`endif
          end
        end
      end

      S_WAIT: begin
        drink0 = drink_in & ~owner;
        drink1 = drink_in & owner;
        back0  = owner ? 2'b00 : back_in;
        back1  = owner ? back_in : 2'b00;
        if (drink_in || cancel) begin
          state_d   = S_IDLE;
          grant_d   = 2'b00;
          rr_last_d = owner;
          cancel_d  = 1'b0;
        end else begin
          state_d = S_SERVE;
        end
      end

      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
    endcase

    // A reset cycle forwards nothing, even mid-session.
    if (reset) begin
      coin_out  = COIN_NONE;
      coin_rdy0 = 1'b0;
      coin_rdy1 = 1'b0;
      drink0    = 1'b0;
      drink1    = 1'b0;
      back0     = 2'b00;
      back1     = 2'b00;
    end
  end

endmodule

// File: doc/vend_arbiter.md
VEND_ARBITER -- requirements
Module: vend_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 8, idle cycles allowed in SERVE before forced cancel (range 2..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0 / req1  input  1  customer 0/1 requests the vending machine.
REQ-005 coin0 / coin1  input  2  customer coin: 00 none, 01 half unit, 10 one unit, 11 cancel.
REQ-006 coin_rdy0 / coin_rdy1  output  1  a coin on that port is accepted this cycle.
REQ-007 grant  output  2  one-hot session owner (bit0 = customer 0); 00 when idle.
REQ-008 coin_out  output  2  coin forwarded to the drink machine, same encoding as coin0.
REQ-009 drink_in  input  1  drink machine dispense pulse.
REQ-010 back_in  input  2  drink machine change/refund value.
REQ-011 drink0 / drink1  output  1  dispense pulse routed to the owner.
REQ-012 back0 / back1  output  2  change routed to the owner; 00 for non-owner.

Function
REQ-013 FSM states SHALL be IDLE, SERVE and WAIT, with a registered owner index and a registered round-robin pointer.
REQ-014 IDLE: when any req is high, the FSM SHALL register the owner and enter SERVE; grant SHALL become valid the cycle after req is sampled.
REQ-015 Both req high in IDLE: the FSM SHALL grant the requester other than the last-served one; after reset, customer 0 wins.
REQ-016 SERVE: coin_rdy of the owner SHALL be 1; coin_rdy of the non-owner SHALL be 0; coin_out SHALL equal the owner's coin combinationally.
REQ-017 SERVE with an owner coin != 00: the coin SHALL be accepted and the FSM SHALL enter WAIT; a coin of 11 SHALL set a registered cancel flag.
REQ-018 WAIT (one cycle): coin_out SHALL be 00, coin_rdy0/1 SHALL be 0, drink_in/back_in SHALL route to the owner's drink/back ports.
REQ-019 WAIT exit: drink_in=1 or cancel flag set -> IDLE, grant 00, pointer updated to the owner, cancel flag cleared; otherwise -> SERVE.
REQ-020 Outside WAIT: drink0/1 and back0/1 SHALL be 0, and drink_in/back_in SHALL be ignored.
REQ-021 Deasserting req during a session SHALL NOT end the session; the non-owner's coins SHALL never reach coin_out.
REQ-022 Outside SERVE (and the timeout cycle), coin_out SHALL be 00.

Reset
REQ-023 On reset=1 at a clock edge: state IDLE, grant 00, owner 0, pointer so customer 0 is preferred, cancel flag 0, timeout counter 0.
REQ-024 During and after reset: coin_out 00, coin_rdy0/1 0, drink0/1 0, back0/1 00, until the first grant.
REQ-025 Reset asserted mid-session SHALL abort the session immediately without forwarding any coin that cycle.

Configuration
REQ-026 Macro VEND_ARB_TIMEOUT_EN defined: a counter SHALL count consecutive SERVE cycles with owner coin 00, and SHALL clear on coin acceptance or on entering SERVE from IDLE.
REQ-027 With VEND_ARB_TIMEOUT_EN, on the cycle the counter reaches TIMEOUT-1: coin_out SHALL be 11, coin_rdy SHALL be 0, cancel flag SHALL set, and the FSM SHALL enter WAIT.
REQ-028 Without VEND_ARB_TIMEOUT_EN: no counter; the session SHALL end only by drink_in or an owner cancel; TIMEOUT SHALL be unused.

Verification
REQ-029 Scenario: reset, req0=1 -> grant=01 next cycle; coin0=10 -> coin_out=10, WAIT; coin0=01 with drink_in=1, back_in=00 in WAIT -> drink0=1, grant=00 next cycle.
REQ-030 Scenario: req0=req1=1 after reset -> grant=01 first; after a dispense -> grant=10; after the next dispense with req0=req1=1 -> grant=01.
REQ-031 Scenario: owner 1 inserts 10 then 11, back_in=10 in WAIT -> back1=10, back0=00, grant=00.
REQ-032 Scenario: coin1=10 while grant=01 -> coin_out=00, coin_rdy1=0, no state change.
REQ-033 Scenario: VEND_ARB_TIMEOUT_EN, TIMEOUT=8, owner idle for 8 SERVE cycles -> coin_out=11 on the 8th cycle; back_in=01 next cycle -> back0=01, grant=00. The same stimulus without the macro SHALL keep grant=01.
REQ-034 Scenario: reset=1 in SERVE with coin0=10 -> coin_out=00 that cycle, grant=00 next cycle, and customer 0 preferred on the next contention.
